// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op codes, FSM encoding and sign/magnitude helper for the multiply/divide unit.
package mdu_pkg;
   localparam int XLEN = 32;
   localparam logic [3:0] MDU_MULT  = 4'd8;
   localparam logic [3:0] MDU_MULTU = 4'd9;
   localparam logic [3:0] MDU_DIV   = 4'd10;
   localparam logic [3:0] MDU_DIVU  = 4'd11;
   localparam logic [3:0] MDU_MTHI  = 4'd12;
   localparam logic [3:0] MDU_MTLO  = 4'd13;
   localparam logic [3:0] MDU_MADD  = 4'd14;
   localparam logic [3:0] MDU_MSUB  = 4'd15;

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

   // Returns {sign, |x|}; unsigned ops always report a positive operand.
   function automatic logic [XLEN:0] abs_sign(input logic [XLEN-1:0] x, input logic signed_op);
      logic s;
      s = signed_op & x[XLEN-1];
      return {s, s ? -x : x};
   endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: request/result bundle between the EX stage and the multiply/divide unit.
interface mdu_if #(parameter int WIDTH = 32);
   logic             Start;
   logic [3:0]       ALUOp;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Hi;
   logic [WIDTH-1:0] Lo;
   modport master (output Start, ALUOp, A, B, input Busy, Done, Hi, Lo);
   modport slave  (input Start, ALUOp, A, B, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/mdu_datapath.sv
// mdu_datapath: one-bit-per-clock shift/add multiplier and restoring divider on unsigned magnitudes.
module mdu_datapath #(parameter int WIDTH = 32) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic               is_div,
   input  logic [WIDTH-1:0]   a_mag,
   input  logic [WIDTH-1:0]   b_mag,
   output logic [2*WIDTH-1:0] acc
);
   logic [WIDTH-1:0] opd;
   logic             mode_div;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   diff;
   logic             ge;

   // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : {(WIDTH+1){1'b0}});
      rem_sh = acc[2*WIDTH-1:WIDTH-1];
      diff   = rem_sh - {1'b0, opd};
      ge     = rem_sh >= {1'b0, opd};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc      <= '0;
         opd      <= '0;
         mode_div <= 1'b0;
      end else if (load) begin
         acc      <= {{WIDTH{1'b0}}, is_div ? a_mag : b_mag};
         opd      <= is_div ? b_mag : a_mag;
         mode_div <= is_div;
      end else if (step) begin
         acc <= mode_div ? {ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc[WIDTH-2:0], ge}
                         : {sum, acc[WIDTH-1:1]};
      end
   end
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle MIPS multiply/divide unit with HI/LO registers.
// Optional MADD/MSUB accumulate ops are enabled by defining MDU_MADD_EN.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = 6
) (
   input logic  Clk,
   input logic  Rst_n,
   mdu_if.slave bus
);
   state_t             state, nxt;
   logic [CNT_W-1:0]   cnt;
   logic [3:0]         op;
   logic               sp, sr, dz, done;
   logic [WIDTH-1:0]   hi, lo;
   logic [2*WIDTH-1:0] acc, prod, mul_res, div_res, res;
   logic [WIDTH:0]     sa_m, sb_m;
   logic               is_mul, is_div, sgn, go;

   always_comb begin
`ifdef MDU_MADD_EN
      is_mul  = bus.ALUOp inside {MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MSUB};
`else
      is_mul  = bus.ALUOp inside {MDU_MULT, MDU_MULTU};
`endif
      is_div  = bus.ALUOp inside {MDU_DIV, MDU_DIVU};
      sgn     = bus.ALUOp inside {MDU_MULT, MDU_DIV, MDU_MADD, MDU_MSUB};
      go      = state == IDLE && bus.Start && (is_mul || is_div);
      sa_m    = abs_sign(bus.A, sgn);
      sb_m    = abs_sign(bus.B, sgn);
      nxt     = state == IDLE ? (go ? RUN : IDLE)
              : state == RUN  ? (cnt == CNT_W'(WIDTH - 1) ? FIX : RUN) : IDLE;
      prod    = sp ? -acc : acc;
`ifdef MDU_MADD_EN
      mul_res = op == MDU_MADD ? {hi, lo} + prod : op == MDU_MSUB ? {hi, lo} - prod : prod;
`else
      mul_res = prod;
`endif
      // divide by zero leaves remainder = A naturally; only the quotient needs forcing
      div_res = {sr ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
                 dz ? {WIDTH{1'b1}} : (sp ? -acc[WIDTH-1:0] : acc[WIDTH-1:0])};
      res     = op inside {MDU_DIV, MDU_DIVU} ? div_res : mul_res;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         op    <= '0;
         sp    <= 1'b0;
         sr    <= 1'b0;
         dz    <= 1'b0;
         done  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= nxt;
         cnt   <= go ? '0 : state == RUN ? cnt + 1'b1 : cnt;
         done  <= state == FIX || (state == IDLE && bus.Start && bus.ALUOp inside {MDU_MTHI, MDU_MTLO});
         if (go) begin
            op <= bus.ALUOp;
            sp <= sa_m[WIDTH] ^ sb_m[WIDTH];
            sr <= sa_m[WIDTH];
            dz <= bus.B == '0;
         end
         if (state == FIX) {hi, lo} <= res;
         else if (state == IDLE && bus.Start && bus.ALUOp == MDU_MTHI) hi <= bus.A;
         else if (state == IDLE && bus.Start && bus.ALUOp == MDU_MTLO) lo <= bus.A;
      end
   end

   mdu_datapath #(.WIDTH(WIDTH)) u_dp (
      .clk   (Clk),
      .rst_n (Rst_n),
      .load  (go),
      .step  (state == RUN),
      .is_div(is_div),
      .a_mag (sa_m[WIDTH-1:0]),
      .b_mag (sb_m[WIDTH-1:0]),
      .acc   (acc)
   );

   assign bus.Busy = state != IDLE;
   assign bus.Done = done;
   assign bus.Hi   = hi;
   assign bus.Lo   = lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table, hand-written corner sequences and random ops vs an arithmetic model.
module tb_mult_div_unit;
   import mdu_pkg::*;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a, b, hi, lo;
      int          lat;
   } vec_t;

   logic Clk = 1'b0;
   logic Rst_n = 1'b0;
   int   total = 0;
   int   passed = 0;
   logic [31:0] mhi = '0, mlo = '0;
   vec_t vecs[11];

   always #5 Clk = ~Clk;

   mdu_if bus ();
   mult_div_unit dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus.slave));

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", nm, got, exp);
   endtask

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
      bus.Start = 1'b1;
      bus.ALUOp = op;
      bus.A     = a;
      bus.B     = b;
      tick();
      bus.Start = 1'b0;
      lat = 1;
      while (!bus.Done && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] hi, input logic [31:0] lo);
      int sa, sb;
      logic [63:0] sp;
      sa = a;
      sb = b;
      sp = longint'(sa) * longint'(sb);
      case (op)
         MDU_MULT:  return sp;
         MDU_MULTU: return {32'd0, a} * {32'd0, b};
         MDU_DIV:   return b == 0 ? {a, 32'hFFFF_FFFF}
                         : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? {32'd0, 32'h8000_0000}
                         : {32'(sa % sb), 32'(sa / sb)};
         MDU_DIVU:  return b == 0 ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
         MDU_MTHI:  return {a, lo};
         MDU_MTLO:  return {hi, a};
         MDU_MADD:  return {hi, lo} + sp;
         MDU_MSUB:  return {hi, lo} - sp;
         default:   return {hi, lo};
      endcase
   endfunction

   initial begin
      int lat;
      logic seen;
      logic [63:0] exp, prev;
      logic [3:0] ops[$];

      vecs[0]  = '{MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 34};
      vecs[1]  = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
      vecs[2]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
      vecs[3]  = '{MDU_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 34};
      vecs[4]  = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34};
      vecs[5]  = '{MDU_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 34};
      vecs[6]  = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         34};
      vecs[7]  = '{MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        34};
      vecs[8]  = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34};
      vecs[9]  = '{MDU_MTHI,  32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF, 32'hFFFF_FFFD, 1};
      vecs[10] = '{MDU_MTLO,  32'd1,         32'd0,         32'hDEAD_BEEF, 32'd1,         1};

      bus.Start = 1'b0;
      bus.ALUOp = '0;
      bus.A     = '0;
      bus.B     = '0;
      tick();
      tick();
      chk("reset_busy", 64'(bus.Busy), 64'd0);
      chk("reset_done", 64'(bus.Done), 64'd0);
      chk("reset_hilo", {bus.Hi, bus.Lo}, 64'd0);
      Rst_n = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
         chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         chk($sformatf("vec%0d_hilo", i), {bus.Hi, bus.Lo}, {vecs[i].hi, vecs[i].lo});
         chk($sformatf("vec%0d_busy_at_done", i), 64'(bus.Busy), 64'd0);
         tick();
         chk($sformatf("vec%0d_done_pulse", i), 64'(bus.Done), 64'd0);
      end

      // unknown op code is ignored
      prev = {32'hDEAD_BEEF, 32'd1};
      bus.Start = 1'b1;
      bus.ALUOp = 4'd3;
      bus.A     = 32'h1234_5678;
      tick();
      bus.Start = 1'b0;
      chk("unknown_busy", 64'(bus.Busy), 64'd0);
      chk("unknown_done", 64'(bus.Done), 64'd0);
      tick();
      chk("unknown_hilo", {bus.Hi, bus.Lo}, prev);

      // Start during a MULT is ignored
      bus.Start = 1'b1;
      bus.ALUOp = MDU_MULT;
      bus.A     = 32'd6;
      bus.B     = 32'd7;
      tick();
      bus.Start = 1'b0;
      lat = 1;
      chk("mult_busy_cycle1", 64'(bus.Busy), 64'd1);
      chk("mult_hilo_held", {bus.Hi, bus.Lo}, prev);
      repeat (4) begin
         tick();
         lat++;
      end
      bus.Start = 1'b1;
      bus.ALUOp = MDU_DIVU;
      bus.A     = 32'd100;
      bus.B     = 32'd7;
      tick();
      lat++;
      bus.Start = 1'b0;
      while (!bus.Done && lat < 60) begin
         tick();
         lat++;
      end
      chk("busy_start_lat", 64'(lat), 64'd34);
      chk("busy_start_hilo", {bus.Hi, bus.Lo}, 64'd42);
      tick();

      // asynchronous reset mid-operation
      bus.Start = 1'b1;
      bus.ALUOp = MDU_MULT;
      bus.A     = 32'd3;
      bus.B     = 32'd3;
      tick();
      bus.Start = 1'b0;
      repeat (9) tick();
      #2 Rst_n = 1'b0;
      #1;
      chk("async_rst_busy", 64'(bus.Busy), 64'd0);
      chk("async_rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
      #1 Rst_n = 1'b1;
      tick();
      chk("after_rst_busy", 64'(bus.Busy), 64'd0);
      seen = 1'b0;
      repeat (30) begin
         tick();
         seen |= bus.Done;
      end
      chk("after_rst_no_done", 64'(seen), 64'd0);

      // accumulate ops
      issue(MDU_MTHI, 32'd0, 32'd0, lat);
      issue(MDU_MTLO, 32'd10, 32'd0, lat);
      chk("pre_madd_hilo", {bus.Hi, bus.Lo}, 64'd10);
      tick();
`ifdef MDU_MADD_EN
      issue(MDU_MADD, 32'hFFFF_FFFE, 32'd3, lat);
      chk("madd_lat", 64'(lat), 64'd34);
      chk("madd_hilo", {bus.Hi, bus.Lo}, 64'd4);
      mlo = 32'd4;
      ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MADD, MDU_MSUB};
`else
      bus.Start = 1'b1;
      bus.ALUOp = MDU_MADD;
      bus.A     = 32'hFFFF_FFFE;
      bus.B     = 32'd3;
      tick();
      bus.Start = 1'b0;
      seen = bus.Done | bus.Busy;
      repeat (40) begin
         tick();
         seen |= bus.Done;
      end
      chk("madd_ignored_done", 64'(seen), 64'd0);
      chk("madd_ignored_hilo", {bus.Hi, bus.Lo}, 64'd10);
      mlo = 32'd10;
      ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO};
`endif
      mhi = 32'd0;
      tick();

      for (int i = 0; i < 40; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = ops[$urandom_range(0, ops.size() - 1)];
         a  = $urandom_range(0, 7) == 0 ? 32'h8000_0000 : $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom;
         endcase
         exp = model(op, a, b, mhi, mlo);
         issue(op, a, b, lat);
         chk($sformatf("rand%0d_op%0d_lat", i, op), 64'(lat), op inside {MDU_MTHI, MDU_MTLO} ? 64'd1 : 64'd34);
         chk($sformatf("rand%0d_op%0d_hilo", i, op), {bus.Hi, bus.Lo}, exp);
         {mhi, mlo} = exp;
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
